// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage load/store initiator with req/ack handshake, lane steering and timeout
module dmem_access_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] a,
  input  logic [DATA_W-1:0]     wd,
  input  logic [2:0]            Funct3,
  output logic [DATA_W-1:0]     rd,
  output logic                  busy,
  output logic                  done,
  output logic                  misalign,
  output logic                  err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DM_ADDRESS-3:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic req, wr, is_b, is_h, mis, accept, to_hit;
  logic [1:0] off;
  logic [2:0] f3_q;
  logic [CW-1:0] cnt;
  logic [3:0] be_nx;
  logic [DATA_W-1:0] wdata_nx, lane, load_val;
  // decode the pipeline request: size, alignment, acceptance and outgoing lanes
  always_comb begin
    req = MemRead | MemWrite;
    wr = MemWrite & ~MemRead;
    is_b = (Funct3 == 3'b000) || (Funct3 == 3'b100);
    is_h = (Funct3 == 3'b001) || (Funct3 == 3'b101);
    mis = is_h ? a[0] : (!is_b && a[1:0] != 2'b00);
    misalign = (state == IDLE) && req && mis;
    accept = (state == IDLE) && req && !mis;
    busy = accept || (state == WAIT);
    done = (state == RESP);
    to_hit = (state == WAIT) && !mem_ack && (cnt == CW'(TIMEOUT - 1));
    be_nx = !wr ? 4'b1111 : is_b ? 4'b0001 << a[1:0] : is_h ? 4'b0011 << a[1:0] : 4'b1111;
    wdata_nx = is_b ? {4{wd[7:0]}} : is_h ? {2{wd[15:0]}} : wd;
  end
  // select the addressed lane of the returned word and extend it
  always_comb begin
    lane = mem_rdata >> {off, 3'b000};
    load_val = (f3_q == 3'b000) ? {{24{lane[7]}}, lane[7:0]} :
               (f3_q == 3'b100) ? {24'd0, lane[7:0]} :
               (f3_q == 3'b001) ? {{16{lane[15]}}, lane[15:0]} :
               (f3_q == 3'b101) ? {16'd0, lane[15:0]} : mem_rdata;
  end
  // next state: IDLE -> WAIT on accept, WAIT -> RESP on ack or timeout, RESP -> IDLE always
  always_comb begin
    state_nx = state;
    state_nx = accept ? WAIT :
               ((state == WAIT) && (mem_ack || to_hit)) ? RESP :
               (state == RESP) ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end
  // request issue/hold, load capture, timeout counting and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd <= '0;
      err <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_wdata <= '0;
      cnt <= '0;
      off <= '0;
      f3_q <= '0;
    end else if (accept) begin
      off <= a[1:0];
      f3_q <= Funct3;
      mem_we <= wr;
      mem_addr <= a[DM_ADDRESS-1:2];
      mem_be <= be_nx;
      mem_wdata <= wdata_nx;
      mem_req <= 1'b1;
      err <= 1'b0;
      cnt <= '0;
    end else if (state == WAIT) begin
      if (mem_ack) begin
        mem_req <= 1'b0;
        if (!mem_we) rd <= load_val;
      end else if (to_hit) begin
        mem_req <= 1'b0;
        err <= 1'b1;
        if (!mem_we) rd <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: randomized self-checking bench with a byte-level reference model
module tb_dmem_access_unit;
  logic clk = 0, reset = 0, MemRead = 0, MemWrite = 0, mem_ack = 0, mr2 = 0, ack2 = 0, zero = 0;
  logic [8:0] a = 0;
  logic [31:0] wd = 0, mem_rdata = 0;
  logic [2:0] Funct3 = 0;
  logic [31:0] rd, mem_wdata, rd2, wdata2;
  logic busy, done, misalign, err, mem_req, mem_we;
  logic busy2, done2, mis2, err2, req2, we2;
  logic [6:0] mem_addr, addr2;
  logic [3:0] mem_be, be2;
  int checks = 0, errors = 0, nbusy, ndone;
  logic [31:0] model_rd = 0;

  dmem_access_unit dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd),
    .Funct3(Funct3), .rd(rd), .busy(busy), .done(done), .misalign(misalign), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  dmem_access_unit #(.TIMEOUT(4)) dut2 (
    .clk(clk), .reset(reset), .MemRead(mr2), .MemWrite(zero), .a(a), .wd(wd),
    .Funct3(Funct3), .rd(rd2), .busy(busy2), .done(done2), .misalign(mis2), .err(err2),
    .mem_req(req2), .mem_we(we2), .mem_addr(addr2), .mem_be(be2),
    .mem_wdata(wdata2), .mem_rdata(mem_rdata), .mem_ack(ack2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int size_of(input logic [2:0] f3);
    return (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : 4;
  endfunction

  function automatic logic [3:0] exp_be(input int n, input logic [1:0] off);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] exp_wd(input int n, input logic [31:0] d);
    longint unsigned m;
    m = 64'(d) % (64'd1 << (8 * n));
    return 32'(m * (n == 1 ? 64'h01010101 : n == 2 ? 64'h00010001 : 64'd1));
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    int n;
    longint unsigned v;
    n = size_of(f3);
    v = (64'(w) >> (8 * off)) % (64'd1 << (8 * n));
    if ((f3 == 0 || f3 == 1) && v >= (64'd1 << (8 * n - 1))) v = v + 64'hFFFFFFFF - (64'd1 << (8 * n)) + 1;
    return 32'(v);
  endfunction

  task automatic access(input bit mr, input bit mw, input logic [8:0] addr, input logic [2:0] f3,
                        input logic [31:0] data, input logic [31:0] rdat, input int dly);
    bit wr;
    int n;
    logic [3:0] ebe;
    logic [31:0] ewd;
    wr = mw && !mr;
    n = size_of(f3);
    ebe = wr ? exp_be(n, addr[1:0]) : 4'hF;
    ewd = exp_wd(n, data);
    MemRead = mr; MemWrite = mw; a = addr; Funct3 = f3; wd = data; mem_rdata = rdat;
    nbusy = 0; ndone = 0;
    @(negedge clk);
    nbusy += int'(busy); ndone += int'(done);
    checks++;
    if ({busy, done, misalign, mem_req} !== 4'b1000) begin
      errors++; $display("FAIL accept_cycle got %b exp 1000 addr=%h f3=%0d", {busy, done, misalign, mem_req}, addr, f3);
    end
    for (int c = 1; c <= dly; c++) begin
      @(posedge clk); #1;
      mem_ack = (c == dly);
      @(negedge clk);
      nbusy += int'(busy); ndone += int'(done);
      checks++;
      if ({busy, done, mem_req, mem_we, mem_addr, mem_be} !== {3'b101, wr, addr[8:2], ebe}) begin
        errors++;
        $display("FAIL wait_outputs cycle %0d got %b_%b_%h_%b exp %b_%b_%h_%b", c,
                 {busy, done, mem_req}, mem_we, mem_addr, mem_be, 3'b101, wr, addr[8:2], ebe);
      end
      if (wr) begin
        checks++;
        if (mem_wdata !== ewd) begin
          errors++; $display("FAIL mem_wdata got %h exp %h", mem_wdata, ewd);
        end
      end
    end
    @(posedge clk); #1;
    mem_ack = 0; MemRead = 0; MemWrite = 0;
    if (!wr) model_rd = exp_load(f3, addr[1:0], rdat);
    @(negedge clk);
    nbusy += int'(busy); ndone += int'(done);
    checks++;
    if ({busy, done, mem_req} !== 3'b010) begin
      errors++; $display("FAIL resp_cycle got %b exp 010", {busy, done, mem_req});
    end
    checks++;
    if (rd !== model_rd) begin
      errors++; $display("FAIL rd got %h exp %h (f3=%0d addr=%h rdata=%h)", rd, model_rd, f3, addr, rdat);
    end
    @(posedge clk); #1;
  endtask

  task automatic try_misaligned(input bit mr, input bit mw, input logic [8:0] addr, input logic [2:0] f3);
    MemRead = mr; MemWrite = mw; a = addr; Funct3 = f3; wd = $urandom;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({misalign, busy, mem_req, done} !== 4'b1000) begin
        errors++; $display("FAIL misalign addr=%h f3=%0d got %b exp 1000", addr, f3, {misalign, busy, mem_req, done});
      end
      @(posedge clk); #1;
    end
    MemRead = 0; MemWrite = 0;
    @(negedge clk);
    checks++;
    if ({misalign, busy, mem_req, rd} !== {3'b000, model_rd}) begin
      errors++; $display("FAIL misalign_release got %b rd=%h exp 000 rd=%h", {misalign, busy, mem_req}, rd, model_rd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    wd = 32'hDEADBEEF; a = 9'h1FF; Funct3 = 3'b010;
    #3;
    checks++;
    if ({rd, busy, done, misalign, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_outputs rd=%h mem_wdata=%h mem_be=%b mem_addr=%h flags=%b exp all zero",
                         rd, mem_wdata, mem_be, mem_addr, {busy, done, misalign, err, mem_req, mem_we});
    end
    @(posedge clk); #1;
    reset = 1;
    MemRead = 1; a = 9'h010; Funct3 = 3'b010;
    @(posedge clk); #1;
    checks++;
    if ({mem_req, busy} !== 2'b11) begin
      errors++; $display("FAIL pre_async_reset got %b exp 11", {mem_req, busy});
    end
    #2 reset = 0;
    #1;
    checks++;
    if ({mem_req, mem_be, mem_addr} !== '0) begin
      errors++; $display("FAIL async_reset_drop got req=%b be=%b addr=%h exp 0", mem_req, mem_be, mem_addr);
    end
    MemRead = 0;
    model_rd = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_byte;
    access(0, 1, 9'h006, 3'b000, 32'h000000A5, $urandom, 1);
    checks++;
    if ({mem_addr, mem_be, mem_wdata} !== {7'h01, 4'b0100, 32'hA5A5A5A5}) begin
      errors++; $display("FAIL sb_fields got %h %b %h exp 01 0100 a5a5a5a5", mem_addr, mem_be, mem_wdata);
    end
  endtask

  task automatic test_loads;
    access(1, 0, 9'h003, 3'b000, 0, 32'h80FF1234, 1);
    checks++;
    if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb got %h exp ffffff80", rd); end
    access(1, 0, 9'h003, 3'b100, 0, 32'h80FF1234, 2);
    checks++;
    if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu got %h exp 00000080", rd); end
    access(1, 0, 9'h002, 3'b001, 0, 32'h80FF1234, 1);
    checks++;
    if (rd !== 32'hFFFF80FF) begin errors++; $display("FAIL lh got %h exp ffff80ff", rd); end
    access(0, 1, 9'h002, 3'b001, 32'h1234BEEF, $urandom, 1);
    checks++;
    if ({mem_be, mem_wdata} !== {4'b1100, 32'hBEEFBEEF}) begin
      errors++; $display("FAIL sh_fields got %b %h exp 1100 beefbeef", mem_be, mem_wdata);
    end
  endtask

  task automatic test_lw_delay;
    logic [31:0] r;
    r = $urandom;
    access(1, 0, 9'h010, 3'b010, 0, r, 5);
    checks++;
    if (nbusy != 6 || ndone != 1) begin
      errors++; $display("FAIL lw_delay busy_cycles=%0d done_pulses=%0d exp 6 and 1", nbusy, ndone);
    end
    checks++;
    if (rd !== r) begin errors++; $display("FAIL lw_delay_rd got %h exp %h", rd, r); end
  endtask

  task automatic test_misalign;
    try_misaligned(1, 0, 9'h012, 3'b010);
    try_misaligned(0, 1, 9'h001, 3'b001);
    try_misaligned(1, 0, 9'h0A3, 3'b101);
  endtask

  task automatic test_random;
    logic [2:0] codes [8];
    logic [2:0] f3;
    logic [8:0] addr;
    int n;
    bit mr, mw;
    codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    for (int i = 0; i < 60; i++) begin
      f3 = codes[$urandom_range(0, 7)];
      n = size_of(f3);
      addr = 9'($urandom);
      case ($urandom_range(0, 3))
        0: begin mr = 1; mw = 0; end
        1: begin mr = 1; mw = 1; end
        default: begin mr = 0; mw = 1; end
      endcase
      if (n > 1 && $urandom_range(0, 5) == 0) begin
        addr = (n == 2) ? (addr | 9'd1) : ((addr & ~9'd3) | 9'($urandom_range(1, 3)));
        try_misaligned(mr, mw, addr, f3);
      end else begin
        addr = addr & ~9'(n - 1);
        access(mr, mw, addr, f3, $urandom, $urandom, $urandom_range(1, 6));
      end
    end
  endtask

  task automatic test_timeout;
    a = 9'h010; Funct3 = 3'b010; mem_rdata = 32'h12345678; mr2 = 1;
    @(posedge clk); #1;
    ack2 = 1;
    @(posedge clk); #1;
    ack2 = 0; mr2 = 0;
    @(negedge clk);
    checks++;
    if ({done2, err2, rd2} !== {2'b10, 32'h12345678}) begin
      errors++; $display("FAIL t4_preload got done=%b err=%b rd=%h exp 1 0 12345678", done2, err2, rd2);
    end
    @(posedge clk); #1;
    mr2 = 1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({req2, busy2, err2, done2} !== 4'b1100) begin
        errors++; $display("FAIL t4_wait cycle %0d got %b exp 1100", c, {req2, busy2, err2, done2});
      end
    end
    @(posedge clk); #1;
    mr2 = 0;
    @(negedge clk);
    checks++;
    if ({req2, done2, busy2, err2, rd2} !== {4'b0101, 32'h0}) begin
      errors++; $display("FAIL t4_timeout got %b rd=%h exp 0101 rd=0", {req2, done2, busy2, err2}, rd2);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({err2, done2} !== 2'b10) begin
      errors++; $display("FAIL t4_sticky got %b exp 10", {err2, done2});
    end
    mr2 = 1; mem_rdata = 32'hCAFEF00D;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      ack2 = (c == 4);
      @(negedge clk);
      checks++;
      if ({req2, err2} !== 2'b10) begin
        errors++; $display("FAIL t4_clear cycle %0d got %b exp 10", c, {req2, err2});
      end
    end
    @(posedge clk); #1;
    ack2 = 0; mr2 = 0;
    @(negedge clk);
    checks++;
    if ({done2, err2, rd2} !== {2'b10, 32'hCAFEF00D}) begin
      errors++; $display("FAIL t4_ack_wins got done=%b err=%b rd=%h exp 1 0 cafef00d", done2, err2, rd2);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_store_byte;
    test_loads;
    test_lw_delay;
    test_misalign;
    test_random;
    test_timeout;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
